// File: rtl/tmr_pkg.sv
// -----------------------------------------------------------------------------
// tmr_pkg
// Shared definitions for the TMR rollback controller and its checkpoint buffer:
//   - tmr_state_e   : recovery FSM states
//   - vote_cls_e    : classification of one voter agreement vector
//   - FAULT_*       : fault_core encoding (0 none, 1 A, 2 B, 3 C)
//   - VS_*          : voter_state patterns {AB, BC, AC} with a single culprit
//   - RESET_PC      : PC restored when no checkpoint exists
//   - classify_vote : maps voter_state to a class plus the faulty core
//   - sat_inc       : 8-bit saturating increment for the error counters
// -----------------------------------------------------------------------------
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DEGRADED,
    ST_RESYNC,
    ST_FATAL
  } tmr_state_e;

  typedef enum logic [1:0] {
    CLS_AGREE,
    CLS_SINGLE,
    CLS_NOMAJ
  } vote_cls_e;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_A    = 2'd1;
  localparam logic [1:0] FAULT_B    = 2'd2;
  localparam logic [1:0] FAULT_C    = 2'd3;

  // A single pair agreeing means the core outside that pair is the odd one out.
  localparam logic [2:0] VS_AGREE   = 3'b111;
  localparam logic [2:0] VS_C_FAULT = 3'b100;
  localparam logic [2:0] VS_A_FAULT = 3'b010;
  localparam logic [2:0] VS_B_FAULT = 3'b001;

  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    vote_cls_e  cls;
    logic [1:0] core;
  } vote_t;

  // Any pattern other than full agreement or exactly one agreeing pair has no
  // trustworthy majority (including the logically inconsistent two-pair cases).
  function automatic vote_t classify_vote(input logic [2:0] vs);
    vote_t v;
    v.cls  = CLS_NOMAJ;
    v.core = FAULT_NONE;
    case (vs)
      VS_AGREE:   v.cls = CLS_AGREE;
      VS_C_FAULT: begin v.cls = CLS_SINGLE; v.core = FAULT_C; end
      VS_A_FAULT: begin v.cls = CLS_SINGLE; v.core = FAULT_A; end
      VS_B_FAULT: begin v.cls = CLS_SINGLE; v.core = FAULT_B; end
      default:    v.cls = CLS_NOMAJ;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/tmr_ckpt_buf.sv
// -----------------------------------------------------------------------------
// tmr_ckpt_buf
// Circular history of fully-agreed PCs used as rollback checkpoints.
// When full, a push overwrites the oldest entry and the read pointer moves
// with it in the same cycle, so oldest_pc always names the oldest survivor.
// A load clears the history and leaves load_pc as the only entry (load wins
// over push if both are asserted).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_pc    : append a checkpoint
//   load, load_pc    : clear and reload with a single entry
//   oldest_pc        : oldest valid entry (meaningless while fill == 0)
//   fill             : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module tmr_ckpt_buf
  import tmr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic                     load,
  input  logic [31:0]              load_pc,
  output logic [31:0]              oldest_pc,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;

  assign full      = (fill == CW'(DEPTH));
  assign oldest_pc = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (load) begin
      mem[0] <= load_pc;
      rd_ptr <= '0;
      wr_ptr <= PW'(1);
      fill   <= CW'(1);
    end else if (push) begin
      mem[wr_ptr] <= push_pc;
      wr_ptr      <= wr_ptr + PW'(1);
      if (full) rd_ptr <= rd_ptr + PW'(1);
      else      fill   <= fill + CW'(1);
    end
  end

endmodule

// File: rtl/tmr_rollback_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_rollback_ctrl
// Recovery controller behind the TMR voter of the triple-core RISC-V.
// Tracks agreed PCs as checkpoints, classifies disagreements, and on a
// persistent or unmaskable fault holds all cores in reset while presenting a
// rollback PC. Repeated recoveries without a clean window end in sticky FATAL.
// Optional feature macro: TMR_ERR_CNT_EN (per-core saturating error counters;
// when undefined the err_cnt_* outputs are tied to zero).
// Ports:
//   clk, rst_in          : clock, asynchronous active-low reset
//   voter_state[2:0]     : agreement vector {AB, BC, AC}
//   pc_voted[31:0]       : voted PC
//   memwrite_voted       : voted MemWrite
//   mem_write_safe       : MemWrite gated for memory (combinational)
//   core_rst_n[2:0]      : per-core hold, active-low, {A, B, C}
//   pc_restore_en        : cores load pc_restore while high
//   pc_restore[31:0]     : rollback PC
//   fault_core[1:0]      : last identified faulty core (0 none, 1 A, 2 B, 3 C)
//   tmr_fatal            : sticky unrecoverable flag
//   err_cnt_a/b/c[7:0]   : per-core saturating fault counters
// -----------------------------------------------------------------------------
module tmr_rollback_ctrl
  import tmr_pkg::*;
#(
  parameter int CKPT_DEPTH    = 4,
  parameter int FAULT_THRESH  = 3,
  parameter int RESYNC_CYCLES = 4,
  parameter int MAX_RETRY     = 2
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [2:0]  voter_state,
  input  logic [31:0] pc_voted,
  input  logic        memwrite_voted,
  output logic        mem_write_safe,
  output logic [2:0]  core_rst_n,
  output logic        pc_restore_en,
  output logic [31:0] pc_restore,
  output logic [1:0]  fault_core,
  output logic        tmr_fatal,
  output logic [7:0]  err_cnt_a,
  output logic [7:0]  err_cnt_b,
  output logic [7:0]  err_cnt_c
);

  localparam int CW = $clog2(CKPT_DEPTH) + 1;
  localparam int SW = $clog2(FAULT_THRESH + 1);
  localparam int HW = $clog2(RESYNC_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 2);

  tmr_state_e    state;
  vote_t         vote;
  logic          active;
  logic          start_resync;
  logic          resync_last;
  logic [SW-1:0] streak;
  logic [RW-1:0] retry;
  logic [CW-1:0] clean_cnt;
  logic [HW-1:0] hold_cnt;

  logic          ckpt_push;
  logic          ckpt_load;
  logic [31:0]   ckpt_oldest;
  logic [CW-1:0] ckpt_fill;

  assign vote   = classify_vote(voter_state);
  assign active = (state == ST_RUN) || (state == ST_DEGRADED);

  assign mem_write_safe = memwrite_voted & active & (vote.cls != CLS_NOMAJ);

  // streak is zero whenever we are in RUN, so the threshold test also covers
  // a threshold of one from RUN.
  assign start_resync = active && (
                          (vote.cls == CLS_NOMAJ) ||
                          ((vote.cls == CLS_SINGLE) &&
                           (((state == ST_DEGRADED) && (vote.core != fault_core)) ||
                            (streak >= SW'(FAULT_THRESH - 1)))));

  assign resync_last = (state == ST_RESYNC) && (hold_cnt == HW'(RESYNC_CYCLES - 1));
  assign ckpt_push   = (state == ST_RUN) && (vote.cls == CLS_AGREE) && !start_resync;
  assign ckpt_load   = resync_last;

  tmr_ckpt_buf #(
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt_buf (
    .clk       (clk),
    .rst_n     (rst_in),
    .push      (ckpt_push),
    .push_pc   (pc_voted),
    .load      (ckpt_load),
    .load_pc   (pc_restore),
    .oldest_pc (ckpt_oldest),
    .fill      (ckpt_fill)
  );

  // Recovery FSM with registered outputs. Entry into RESYNC is factored out
  // because RUN and DEGRADED reach it through several different causes.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state         <= ST_RUN;
      core_rst_n    <= 3'b111;
      pc_restore_en <= 1'b0;
      pc_restore    <= RESET_PC;
      fault_core    <= FAULT_NONE;
      tmr_fatal     <= 1'b0;
      streak        <= '0;
      retry         <= '0;
      clean_cnt     <= '0;
      hold_cnt      <= '0;
    end else if (start_resync) begin
      state         <= ST_RESYNC;
      core_rst_n    <= 3'b000;
      pc_restore_en <= 1'b1;
      pc_restore    <= (ckpt_fill == '0) ? RESET_PC : ckpt_oldest;
      if (vote.cls == CLS_SINGLE) fault_core <= vote.core;
      streak        <= '0;
      clean_cnt     <= '0;
      hold_cnt      <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (vote.cls == CLS_AGREE) begin
            if (clean_cnt != CW'(CKPT_DEPTH)) clean_cnt <= clean_cnt + CW'(1);
            if (clean_cnt >= CW'(CKPT_DEPTH - 1)) retry <= '0;
          end else begin
            state      <= ST_DEGRADED;
            fault_core <= vote.core;
            streak     <= SW'(1);
            clean_cnt  <= '0;
          end
        end
        ST_DEGRADED: begin
          if (vote.cls == CLS_AGREE) begin
            state  <= ST_RUN;
            streak <= '0;
          end else begin
            streak <= streak + SW'(1);
          end
        end
        ST_RESYNC: begin
          if (resync_last) begin
            retry         <= retry + RW'(1);
            pc_restore_en <= 1'b0;
            if (retry >= RW'(MAX_RETRY)) begin
              state     <= ST_FATAL;
              tmr_fatal <= 1'b1;
            end else begin
              state      <= ST_RUN;
              core_rst_n <= 3'b111;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_FATAL: begin
        end
      endcase
    end
  end

`ifdef TMR_ERR_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [7:0] cnt_c;

  // Votes are only meaningful while the cores run; a no-majority cycle blames
  // every core because the culprit cannot be identified.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt_a <= 8'h0;
      cnt_b <= 8'h0;
      cnt_c <= 8'h0;
    end else if (active) begin
      if (vote.cls == CLS_NOMAJ) begin
        cnt_a <= sat_inc(cnt_a);
        cnt_b <= sat_inc(cnt_b);
        cnt_c <= sat_inc(cnt_c);
      end else if (vote.cls == CLS_SINGLE) begin
        case (vote.core)
          FAULT_A: cnt_a <= sat_inc(cnt_a);
          FAULT_B: cnt_b <= sat_inc(cnt_b);
          FAULT_C: cnt_c <= sat_inc(cnt_c);
          default: begin
          end
        endcase
      end
    end
  end

  assign err_cnt_a = cnt_a;
  assign err_cnt_b = cnt_b;
  assign err_cnt_c = cnt_c;
`else
  assign err_cnt_a = 8'h0;
  assign err_cnt_b = 8'h0;
  assign err_cnt_c = 8'h0;
`endif

endmodule

// File: tb/tb_tmr_rollback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmr_rollback_ctrl
// Directed, self-checking bench for tmr_rollback_ctrl with default parameters.
// Counter expectations follow the TMR_ERR_CNT_EN macro (zero when undefined).
// -----------------------------------------------------------------------------
module tb_tmr_rollback_ctrl;

  localparam int CKPT_DEPTH    = 4;
  localparam int FAULT_THRESH  = 3;
  localparam int RESYNC_CYCLES = 4;
  localparam int MAX_RETRY     = 2;

`ifdef TMR_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {core_rst_n, pc_restore_en, tmr_fatal}
  localparam logic [4:0] ST_OK    = 5'b111_0_0;
  localparam logic [4:0] ST_HOLD  = 5'b000_1_0;
  localparam logic [4:0] ST_DEAD  = 5'b000_0_1;

  logic        clk;
  logic        rst_in;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic        memwrite_voted;
  logic        mem_write_safe;
  logic [2:0]  core_rst_n;
  logic        pc_restore_en;
  logic [31:0] pc_restore;
  logic [1:0]  fault_core;
  logic        tmr_fatal;
  logic [7:0]  err_cnt_a;
  logic [7:0]  err_cnt_b;
  logic [7:0]  err_cnt_c;

  logic [4:0]  status;
  logic [23:0] cnts;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_a    = 8'h0;
  logic [7:0] exp_b    = 8'h0;
  logic [7:0] exp_c    = 8'h0;

  assign status = {core_rst_n, pc_restore_en, tmr_fatal};
  assign cnts   = {err_cnt_a, err_cnt_b, err_cnt_c};

  tmr_rollback_ctrl #(
    .CKPT_DEPTH    (CKPT_DEPTH),
    .FAULT_THRESH  (FAULT_THRESH),
    .RESYNC_CYCLES (RESYNC_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .voter_state    (voter_state),
    .pc_voted       (pc_voted),
    .memwrite_voted (memwrite_voted),
    .mem_write_safe (mem_write_safe),
    .core_rst_n     (core_rst_n),
    .pc_restore_en  (pc_restore_en),
    .pc_restore     (pc_restore),
    .fault_core     (fault_core),
    .tmr_fatal      (tmr_fatal),
    .err_cnt_a      (err_cnt_a),
    .err_cnt_b      (err_cnt_b),
    .err_cnt_c      (err_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_cnts();
    return CNT_EN ? {exp_a, exp_b, exp_c} : 24'h0;
  endfunction

  // Inputs change 1 time unit after a rising edge; the extra #1 lets the
  // combinational gate settle before it is sampled.
  task automatic applyStimulus(input logic [2:0] vs, input logic [31:0] pc, input logic mw);
    voter_state    = vs;
    pc_voted       = pc;
    memwrite_voted = mw;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input logic [2:0] vs);
    for (int i = 0; i < n; i++) begin
      applyStimulus(vs, 32'hFFFF_0000, 1'b1);
      step();
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    applyStimulus(3'b111, 32'h0, 1'b0);
    step();
    step();
    checks++;
    if (status !== ST_OK) begin
      failures++;
      $display("[TB] FAIL reset_status: got %b expected %b", status, ST_OK);
    end
    checks++;
    if ({pc_restore, fault_core} !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_pc_fault: got %h/%0d expected 0/0", pc_restore, fault_core);
    end
    checks++;
    if (cnts !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_cnts: got %h expected 000000", cnts);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_checkpoint();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, 32'(i * 4), 1'b1);
      checks++;
      if (mem_write_safe !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ckpt_msafe[%0d]: got %b expected 1", i, mem_write_safe);
      end
      step();
      checks++;
      if (status !== ST_OK) begin
        failures++;
        $display("[TB] FAIL ckpt_status[%0d]: got %b expected %b", i, status, ST_OK);
      end
    end
  endtask

  // Buffer holds 08,0C,10,14 from the previous test; core C persists for the
  // full threshold, so the rollback target is 0x08.
  task automatic test_single_fault_resync();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b100, 32'h18 + 32'(i * 4), 1'b1);
      checks++;
      if (mem_write_safe !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sf_msafe[%0d]: got %b expected 1", i, mem_write_safe);
      end
      step();
      if (i < 2) begin
        checks++;
        if ({status, fault_core} !== {ST_OK, 2'd3}) begin
          failures++;
          $display("[TB] FAIL sf_degraded[%0d]: got %b/%0d expected %b/3", i, status, fault_core, ST_OK);
        end
      end
    end
    exp_c = exp_c + 8'd3;
    checks++;
    if (cnts !== exp_cnts()) begin
      failures++;
      $display("[TB] FAIL sf_cnts: got %h expected %h", cnts, exp_cnts());
    end
    for (int i = 0; i < RESYNC_CYCLES; i++) begin
      checks++;
      if ({status, pc_restore} !== {ST_HOLD, 32'h8}) begin
        failures++;
        $display("[TB] FAIL sf_hold[%0d]: got %b/%h expected %b/00000008", i, status, pc_restore, ST_HOLD);
      end
      applyStimulus(3'b111, 32'hDEAD_0000, 1'b1);
      checks++;
      if (mem_write_safe !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sf_hold_msafe[%0d]: got %b expected 0", i, mem_write_safe);
      end
      step();
    end
    checks++;
    if (status !== ST_OK) begin
      failures++;
      $display("[TB] FAIL sf_exit: got %b expected %b", status, ST_OK);
    end
  endtask

  task automatic test_transient_fault();
    logic [2:0] vs [3];
    logic       mw [3];
    vs = '{3'b010, 3'b111, 3'b111};
    mw = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vs[i], 32'h100 + 32'(i * 4), mw[i]);
      checks++;
      if (mem_write_safe !== mw[i]) begin
        failures++;
        $display("[TB] FAIL tr_msafe[%0d]: got %b expected %b", i, mem_write_safe, mw[i]);
      end
      step();
      checks++;
      if ({status, fault_core} !== {ST_OK, 2'd1}) begin
        failures++;
        $display("[TB] FAIL tr_status[%0d]: got %b/%0d expected %b/1", i, status, fault_core, ST_OK);
      end
    end
    exp_a = exp_a + 8'd1;
    checks++;
    if (cnts !== exp_cnts()) begin
      failures++;
      $display("[TB] FAIL tr_cnts: got %h expected %h", cnts, exp_cnts());
    end
  endtask

  task automatic test_nomaj();
    applyStimulus(3'b000, 32'h200, 1'b1);
    checks++;
    if (mem_write_safe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nm_msafe: got %b expected 0", mem_write_safe);
    end
    step();
    checks++;
    if ({status, pc_restore} !== {ST_HOLD, 32'h8}) begin
      failures++;
      $display("[TB] FAIL nm_enter: got %b/%h expected %b/00000008", status, pc_restore, ST_HOLD);
    end
    exp_a = exp_a + 8'd1;
    exp_b = exp_b + 8'd1;
    exp_c = exp_c + 8'd1;
    checks++;
    if (cnts !== exp_cnts()) begin
      failures++;
      $display("[TB] FAIL nm_cnts: got %h expected %h", cnts, exp_cnts());
    end
    run_cycles(RESYNC_CYCLES - 1, 3'b000);
    checks++;
    if (status !== ST_HOLD) begin
      failures++;
      $display("[TB] FAIL nm_last_hold: got %b expected %b", status, ST_HOLD);
    end
    step();
    checks++;
    if (status !== ST_OK) begin
      failures++;
      $display("[TB] FAIL nm_exit: got %b expected %b", status, ST_OK);
    end
  endtask

  // Four clean RUN cycles clear the retry budget; the fourth push also wraps
  // the full buffer so 0x200 becomes the oldest entry.
  task automatic test_retry_clear();
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      applyStimulus(3'b111, 32'h200 + 32'(i * 4), i[0]);
      checks++;
      if (mem_write_safe !== i[0]) begin
        failures++;
        $display("[TB] FAIL rc_msafe[%0d]: got %b expected %b", i, mem_write_safe, i[0]);
      end
      step();
    end
  endtask

  task automatic test_fatal();
    logic [2:0] ev [3];
    ev = '{3'b000, 3'b011, 3'b110};
    for (int e = 0; e < 3; e++) begin
      applyStimulus(ev[e], 32'hBAD0, 1'b1);
      step();
      checks++;
      if ({status, pc_restore} !== {ST_HOLD, 32'h200}) begin
        failures++;
        $display("[TB] FAIL ft_enter[%0d]: got %b/%h expected %b/00000200", e, status, pc_restore, ST_HOLD);
      end
      run_cycles(RESYNC_CYCLES, 3'b111);
      if (e < 2) begin
        checks++;
        if (status !== ST_OK) begin
          failures++;
          $display("[TB] FAIL ft_exit[%0d]: got %b expected %b", e, status, ST_OK);
        end
        for (int k = 0; k < 2; k++) begin
          applyStimulus(3'b111, 32'h300 + 32'(e * 'h100) + 32'(k * 4), 1'b0);
          step();
        end
      end
    end
    exp_a = exp_a + 8'd3;
    exp_b = exp_b + 8'd3;
    exp_c = exp_c + 8'd3;
    checks++;
    if (status !== ST_DEAD) begin
      failures++;
      $display("[TB] FAIL ft_fatal: got %b expected %b", status, ST_DEAD);
    end
    applyStimulus(3'b000, 32'h0, 1'b1);
    checks++;
    if (mem_write_safe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ft_msafe: got %b expected 0", mem_write_safe);
    end
    run_cycles(3, 3'b010);
    checks++;
    if ({status, cnts} !== {ST_DEAD, exp_cnts()}) begin
      failures++;
      $display("[TB] FAIL ft_sticky: got %b/%h expected %b/%h", status, cnts, ST_DEAD, exp_cnts());
    end
  endtask

  task automatic test_reset_mid_resync();
    rst_in = 1'b0;
    #1;
    exp_a = 8'h0;
    exp_b = 8'h0;
    exp_c = 8'h0;
    checks++;
    if ({status, pc_restore, fault_core, cnts} !== {ST_OK, 32'h0, 2'd0, 24'h0}) begin
      failures++;
      $display("[TB] FAIL rm_async_from_fatal: got %b/%h/%0d/%h expected %b/0/0/0", status, pc_restore, fault_core, cnts, ST_OK);
    end
    rst_in = 1'b1;
    applyStimulus(3'b111, 32'h500, 1'b0);
    step();
    applyStimulus(3'b111, 32'h504, 1'b0);
    step();
    applyStimulus(3'b101, 32'h508, 1'b0);
    step();
    checks++;
    if ({status, pc_restore} !== {ST_HOLD, 32'h500}) begin
      failures++;
      $display("[TB] FAIL rm_enter: got %b/%h expected %b/00000500", status, pc_restore, ST_HOLD);
    end
    step();
    rst_in = 1'b0;
    #1;
    checks++;
    if ({status, pc_restore, cnts} !== {ST_OK, 32'h0, 24'h0}) begin
      failures++;
      $display("[TB] FAIL rm_async: got %b/%h/%h expected %b/0/0", status, pc_restore, cnts, ST_OK);
    end
    #1;
    rst_in = 1'b1;
    // An empty buffer must roll back to RESET_PC, not to the stale 0x500.
    applyStimulus(3'b000, 32'h600, 1'b0);
    step();
    checks++;
    if ({status, pc_restore} !== {ST_HOLD, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rm_empty_buf: got %b/%h expected %b/00000000", status, pc_restore, ST_HOLD);
    end
    exp_a = exp_a + 8'd1;
    exp_b = exp_b + 8'd1;
    exp_c = exp_c + 8'd1;
    run_cycles(RESYNC_CYCLES, 3'b111);
    checks++;
    if (status !== ST_OK) begin
      failures++;
      $display("[TB] FAIL rm_exit: got %b expected %b", status, ST_OK);
    end
  endtask

  // A second fault on a different core escalates immediately.
  task automatic test_back_to_back();
    applyStimulus(3'b010, 32'h700, 1'b1);
    step();
    checks++;
    if ({status, fault_core} !== {ST_OK, 2'd1}) begin
      failures++;
      $display("[TB] FAIL bb_first: got %b/%0d expected %b/1", status, fault_core, ST_OK);
    end
    applyStimulus(3'b001, 32'h704, 1'b1);
    checks++;
    if (mem_write_safe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bb_msafe: got %b expected 1", mem_write_safe);
    end
    step();
    exp_a = exp_a + 8'd1;
    exp_b = exp_b + 8'd1;
    checks++;
    if ({status, pc_restore, cnts} !== {ST_HOLD, 32'h0, exp_cnts()}) begin
      failures++;
      $display("[TB] FAIL bb_resync: got %b/%h/%h expected %b/0/%h", status, pc_restore, cnts, ST_HOLD, exp_cnts());
    end
  endtask

  initial begin
    rst_in         = 1'b0;
    voter_state    = 3'b111;
    pc_voted       = 32'h0;
    memwrite_voted = 1'b0;
    test_reset();
    test_checkpoint();
    test_single_fault_resync();
    test_transient_fault();
    test_nomaj();
    test_retry_clear();
    test_fatal();
    test_reset_mid_resync();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
